// File: rtl/ping_pong_rd_ctrl_if.sv
// Bus bundle for the ping-pong read sequencer.
// Handshake: sa_advance acts as the ready for issue. An element issues in
// any READ cycle where sa_advance is 1, and its enable/address appear on the
// next cycle. out_valid marks read data at the buffer dout. It is never
// back-pressured: the consumer must accept data whenever out_valid is high.
// state_dbg mirrors the sequencer state (0 IDLE, 1 READ, 2 DRAIN, 3 RELEASE).
interface ping_pong_rd_ctrl_if #(
  parameter int ADDR_WIDTH  = 2,
  parameter int SLICE_WIDTH = 2
);
  logic                   rd_enable;
  logic [1:0]             bank_full;
  logic                   sa_advance;
  logic                   bank0_en;
  logic                   bank1_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [SLICE_WIDTH-1:0] slicing_idx;
  logic                   out_valid;
  logic                   out_last;
  logic                   out_bank;
  logic [1:0]             bank_release;
  logic                   busy;
  logic [15:0]            perf_stall_cnt;
  logic [15:0]            perf_bank_cnt;
  logic [1:0]             state_dbg;

  // Sequencer side
  modport master (
    input  rd_enable, bank_full, sa_advance,
    output bank0_en, bank1_en, rd_addr, slicing_idx, out_valid, out_last,
           out_bank, bank_release, busy, perf_stall_cnt, perf_bank_cnt, state_dbg
  );

  // Environment side (writer, systolic array, buffer consumer)
  modport slave (
    output rd_enable, bank_full, sa_advance,
    input  bank0_en, bank1_en, rd_addr, slicing_idx, out_valid, out_last,
           out_bank, bank_release, busy, perf_stall_cnt, perf_bank_cnt, state_dbg
  );
endinterface

// File: rtl/ping_pong_rd_ctrl.sv
// Read-side sequencer for one ping-pong buffer. Waits for the writer to
// mark the current bank full, walks pass > addr > slice, then hands the bank
// back with a one-cycle release pulse once the final read word has emerged.
// Banks alternate strictly 0, 1, 0, ...
// Optional feature macro: PP_RD_PERF_CNT_EN enables the saturating stall and
// released-bank counters; when undefined both perf ports read as zero.
module ping_pong_rd_ctrl #(
  parameter int DEPTH         = 4,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int TOTAL_MODULES = 4,
  parameter int PASSES        = 1,
  parameter int RD_LATENCY    = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  ping_pong_rd_ctrl_if.master bus
);

  localparam int SLICE_WIDTH = $clog2(TOTAL_MODULES);
  localparam int PASS_WIDTH  = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   cur_bank;
  logic [ADDR_WIDTH-1:0]  addr_cnt;
  logic [SLICE_WIDTH-1:0] slice_cnt;
  logic [PASS_WIDTH-1:0]  pass_cnt;

  logic                   issue;
  logic                   issue_last;
  logic                   slice_end;
  logic                   addr_end;
  logic                   pass_end;

  logic                   en0_q;
  logic                   en1_q;
  logic                   last_q;
  logic                   bank_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [SLICE_WIDTH-1:0] slice_q;
  logic [RD_LATENCY-1:0]  vld_sr;
  logic [RD_LATENCY-1:0]  last_sr;
  logic [RD_LATENCY-1:0]  bank_sr;
  logic [1:0]             release_q;

  assign issue      = (state == READ) && bus.sa_advance;
  assign slice_end  = (slice_cnt == SLICE_WIDTH'(TOTAL_MODULES - 1));
  assign addr_end   = (addr_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign pass_end   = (pass_cnt == PASS_WIDTH'(PASSES - 1));
  assign issue_last = issue && slice_end && addr_end && pass_end;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DRAIN leaves as soon as the final word is visible at the output
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.rd_enable && bus.bank_full[cur_bank]) state_nxt = READ;
      READ:    if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (vld_sr[RD_LATENCY-1] && last_sr[RD_LATENCY-1]) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bank pointer: flips once the current bank has been handed back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cur_bank <= 1'b0;
    else if (state == RELEASE)  cur_bank <= ~cur_bank;
  end

  // Nested walk counters; only an accepted issue moves them, so stalls never skip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_cnt <= '0;
      addr_cnt  <= '0;
      pass_cnt  <= '0;
    end else if (state == RELEASE) begin
      slice_cnt <= '0;
      addr_cnt  <= '0;
      pass_cnt  <= '0;
    end else if (issue) begin
      if (slice_end) begin
        slice_cnt <= '0;
        if (addr_end) begin
          addr_cnt <= '0;
          pass_cnt <= pass_end ? '0 : pass_cnt + 1'b1;
        end else begin
          addr_cnt <= addr_cnt + 1'b1;
        end
      end else begin
        slice_cnt <= slice_cnt + 1'b1;
      end
    end
  end

  // Issue stage: registered enables, address and slice for the buffer read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en0_q   <= 1'b0;
      en1_q   <= 1'b0;
      last_q  <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      slice_q <= '0;
    end else begin
      en0_q  <= issue && !cur_bank;
      en1_q  <= issue && cur_bank;
      last_q <= issue_last;
      bank_q <= cur_bank;
      if (issue) begin
        addr_q  <= addr_cnt;
        slice_q <= slice_cnt;
      end
    end
  end

  // Read-latency shift of valid/last/bank; free-running, never stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr  <= '0;
      last_sr <= '0;
      bank_sr <= '0;
    end else begin
      vld_sr[0]  <= en0_q | en1_q;
      last_sr[0] <= last_q;
      bank_sr[0] <= bank_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
        bank_sr[i] <= bank_sr[i-1];
      end
    end
  end

  // Release pulse is high exactly during the RELEASE state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       release_q <= 2'b00;
    else if (state_nxt == RELEASE)    release_q <= cur_bank ? 2'b10 : 2'b01;
    else                              release_q <= 2'b00;
  end

`ifdef PP_RD_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] bank_cnt;

  // Saturating performance counters, cleared by reset only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      bank_cnt  <= '0;
    end else begin
      if ((state == READ) && !bus.sa_advance && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if ((state == RELEASE) && (bank_cnt != 16'hFFFF))
        bank_cnt <= bank_cnt + 16'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_bank_cnt  = bank_cnt;
`else
  assign bus.perf_stall_cnt = 16'd0;
  assign bus.perf_bank_cnt  = 16'd0;
`endif

  assign bus.bank0_en     = en0_q;
  assign bus.bank1_en     = en1_q;
  assign bus.rd_addr      = addr_q;
  assign bus.slicing_idx  = slice_q;
  assign bus.out_valid    = vld_sr[RD_LATENCY-1];
  assign bus.out_last     = last_sr[RD_LATENCY-1];
  assign bus.out_bank     = bank_sr[RD_LATENCY-1];
  assign bus.bank_release = release_q;
  assign bus.busy         = (state != IDLE);
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_ping_pong_rd_ctrl.sv
// Bench for ping_pong_rd_ctrl. Two instances share the stimulus:
// dut 0 uses the defaults, dut 1 uses PASSES=2, RD_LATENCY=2.
// A transaction-level model predicts every output cycle by cycle; directed
// segments add hand-computed literal expectations.
module tb_ping_pong_rd_ctrl;

  localparam int DEPTH = 4;
  localparam int TM    = 4;
  localparam int AW    = 2;
  localparam int SW    = 2;
  localparam int MAXC  = 8192;

`ifdef PP_RD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rd_enable  = 1'b0;
  logic [1:0] bank_full  = 2'b00;
  logic       sa_advance = 1'b0;

  ping_pong_rd_ctrl_if #(.ADDR_WIDTH(AW), .SLICE_WIDTH(SW)) if_a ();
  ping_pong_rd_ctrl_if #(.ADDR_WIDTH(AW), .SLICE_WIDTH(SW)) if_b ();

  assign if_a.rd_enable  = rd_enable;
  assign if_a.bank_full  = bank_full;
  assign if_a.sa_advance = sa_advance;
  assign if_b.rd_enable  = rd_enable;
  assign if_b.bank_full  = bank_full;
  assign if_b.sa_advance = sa_advance;

  ping_pong_rd_ctrl #(.DEPTH(DEPTH), .TOTAL_MODULES(TM), .PASSES(1), .RD_LATENCY(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  ping_pong_rd_ctrl #(.DEPTH(DEPTH), .TOTAL_MODULES(TM), .PASSES(2), .RD_LATENCY(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  // Output views indexed by instance
  logic [1:0]    o_en[2];
  logic [AW-1:0] o_addr[2];
  logic [SW-1:0] o_slice[2];
  logic          o_valid[2];
  logic          o_last[2];
  logic          o_bank[2];
  logic [1:0]    o_rel[2];
  logic          o_busy[2];
  logic [15:0]   o_pstall[2];
  logic [15:0]   o_pbank[2];

  always_comb begin
    o_en[0] = {if_a.bank1_en, if_a.bank0_en};  o_en[1] = {if_b.bank1_en, if_b.bank0_en};
    o_addr[0] = if_a.rd_addr;                  o_addr[1] = if_b.rd_addr;
    o_slice[0] = if_a.slicing_idx;             o_slice[1] = if_b.slicing_idx;
    o_valid[0] = if_a.out_valid;               o_valid[1] = if_b.out_valid;
    o_last[0] = if_a.out_last;                 o_last[1] = if_b.out_last;
    o_bank[0] = if_a.out_bank;                 o_bank[1] = if_b.out_bank;
    o_rel[0] = if_a.bank_release;              o_rel[1] = if_b.bank_release;
    o_busy[0] = if_a.busy;                     o_busy[1] = if_b.busy;
    o_pstall[0] = if_a.perf_stall_cnt;         o_pstall[1] = if_b.perf_stall_cnt;
    o_pbank[0] = if_a.perf_bank_cnt;           o_pbank[1] = if_b.perf_bank_cnt;
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, k, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int  cyc = 0;
  int  lat[2]   = '{1, 2};
  int  npass[2] = '{1, 2};
  bit  reading[2];
  int  idx[2];
  bit  cb[2];
  int  resume[2];
  int  relc[2];
  logic [1:0] m_en[2];
  int  m_addr[2];
  int  m_slice[2];
  bit  m_busy[2];
  int  m_stall[2];
  int  m_banks[2];
  bit  v_exp[2][MAXC];
  bit  l_exp[2][MAXC];
  bit  b_exp[2][MAXC];
  logic [1:0] r_exp[2][MAXC];

  // Each rising edge decides what the current cycle does and what the outputs
  // must show from the next cycle on: an accepted element appears one cycle
  // later, its data lat cycles after that, and release one cycle after the
  // final word. The bank can restart one cycle after release.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        m_en[k] = 2'b00;
        if (!rst_n) begin
          reading[k] = 0; idx[k] = 0; cb[k] = 0; resume[k] = 0; relc[k] = -1;
          m_stall[k] = 0; m_banks[k] = 0; m_busy[k] = 0; m_addr[k] = 0; m_slice[k] = 0;
          for (int j = 1; j <= 4; j++) begin
            if (cyc + j < MAXC) begin
              v_exp[k][cyc+j] = 0; l_exp[k][cyc+j] = 0; b_exp[k][cyc+j] = 0; r_exp[k][cyc+j] = 2'b00;
            end
          end
        end else begin
          if (reading[k]) begin
            if (sa_advance) begin
              m_en[k][cb[k]] = 1'b1;
              m_addr[k]  = (idx[k] / TM) % DEPTH;
              m_slice[k] = idx[k] % TM;
              if (cyc + 2 + lat[k] < MAXC) begin
                v_exp[k][cyc+1+lat[k]] = 1;
                l_exp[k][cyc+1+lat[k]] = (idx[k] == npass[k]*DEPTH*TM - 1);
                b_exp[k][cyc+1+lat[k]] = cb[k];
              end
              if (idx[k] == npass[k]*DEPTH*TM - 1) begin
                reading[k] = 0;
                if (cyc + 2 + lat[k] < MAXC) r_exp[k][cyc+2+lat[k]] = cb[k] ? 2'b10 : 2'b01;
                relc[k]   = cyc + 2 + lat[k];
                resume[k] = cyc + 3 + lat[k];
                cb[k]     = ~cb[k];
              end
              idx[k]++;
            end else if (m_stall[k] < 65535) begin
              m_stall[k]++;
            end
          end else if (cyc >= resume[k] && rd_enable && bank_full[cb[k]]) begin
            reading[k] = 1;
            idx[k] = 0;
          end
          if (cyc == relc[k] && m_banks[k] < 65535) m_banks[k]++;
          m_busy[k] = reading[k] || (cyc + 1 < resume[k]);
        end
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          chk("rst_en", k, o_en[k], 0);       chk("rst_addr", k, o_addr[k], 0);
          chk("rst_slice", k, o_slice[k], 0); chk("rst_valid", k, o_valid[k], 0);
          chk("rst_last", k, o_last[k], 0);   chk("rst_rel", k, o_rel[k], 0);
          chk("rst_busy", k, o_busy[k], 0);   chk("rst_pstall", k, o_pstall[k], 0);
          chk("rst_pbank", k, o_pbank[k], 0);
        end else if (cyc < MAXC) begin
          chk("en", k, o_en[k], m_en[k]);
          if (m_en[k] != 2'b00) begin
            chk("rd_addr", k, o_addr[k], m_addr[k]);
            chk("slicing_idx", k, o_slice[k], m_slice[k]);
          end
          chk("out_valid", k, o_valid[k], v_exp[k][cyc]);
          if (v_exp[k][cyc]) begin
            chk("out_last", k, o_last[k], l_exp[k][cyc]);
            chk("out_bank", k, o_bank[k], b_exp[k][cyc]);
          end
          chk("bank_release", k, o_rel[k], r_exp[k][cyc]);
          chk("busy", k, o_busy[k], m_busy[k]);
          chk("perf_stall", k, o_pstall[k], PERF_ON ? m_stall[k] : 0);
          chk("perf_bank", k, o_pbank[k], PERF_ON ? m_banks[k] : 0);
        end
      end
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int en_cnt[2], ov_cnt[2], rel_cnt[2];
  int first_en[2], first_ov[2], last_cyc[2], rel_cyc[2];
  logic [3:0] a_issue_q[$];
  logic [1:0] a_rel_q[$];
  logic [1:0] a_first_en;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          if (o_en[k] != 2'b00) begin
            en_cnt[k]++;
            if (first_en[k] < 0) first_en[k] = cyc;
            if (k == 0) begin
              if (a_issue_q.size() == 0) a_first_en = o_en[0];
              a_issue_q.push_back({o_addr[0], o_slice[0]});
            end
          end
          if (o_valid[k]) begin
            ov_cnt[k]++;
            if (first_ov[k] < 0) first_ov[k] = cyc;
            if (o_last[k]) last_cyc[k] = cyc;
          end
          if (o_rel[k] != 2'b00) begin
            rel_cnt[k]++;
            rel_cyc[k] = cyc;
            if (k == 0) a_rel_q.push_back(o_rel[0]);
          end
        end
      end
    end
  end

  function automatic int issue_at(input int i);
    if (i < a_issue_q.size()) return int'(a_issue_q[i]);
    return -1;
  endfunction

  function automatic int rel_at(input int i);
    if (i < a_rel_q.size()) return int'(a_rel_q[i]);
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      en_cnt[k] = 0; ov_cnt[k] = 0; rel_cnt[k] = 0;
      first_en[k] = -1; first_ov[k] = -1; last_cyc[k] = -1; rel_cyc[k] = -1;
    end
    a_issue_q.delete();
    a_rel_q.delete();
    a_first_en = 2'b00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; rd_enable = 1'b0; bank_full = 2'b00; sa_advance = 1'b0;
    cycles(2);
    clear_mon();
    rst_n = 1'b1;
  endtask

  task automatic start(input logic en, input logic [1:0] full, input logic adv);
    cycles(1);
    rd_enable = en; bank_full = full; sa_advance = adv;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (!o_busy[0] && !o_busy[1]) begin
        done = 1;
        break;
      end
    end
    chk(name, 0, done, 1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit done;
    clear_mon();
    cycles(3);

    // Basic bank 0, plus reuse/latency on the second instance
    do_reset();
    start(1'b1, 2'b01, 1'b1);
    cycles(3);
    wait_idle("basic_idle", 200);
    chk("basic_en_cnt", 0, en_cnt[0], 16);
    chk("basic_ov_cnt", 0, ov_cnt[0], 16);
    chk("basic_first", 0, issue_at(0), 4'h0);
    chk("basic_elem5", 0, issue_at(5), 4'b0101);
    chk("basic_elem15", 0, issue_at(15), 4'hF);
    chk("basic_first_bank", 0, a_first_en, 2'b01);
    chk("basic_rel_cnt", 0, a_rel_q.size(), 1);
    chk("basic_rel", 0, rel_at(0), 2'b01);
    chk("basic_lat", 0, first_ov[0] - first_en[0], 1);
    chk("basic_last2rel", 0, rel_cyc[0] - last_cyc[0], 1);
    chk("reuse_en_cnt", 1, en_cnt[1], 32);
    chk("reuse_ov_cnt", 1, ov_cnt[1], 32);
    chk("reuse_lat", 1, first_ov[1] - first_en[1], 2);
    chk("reuse_last2rel", 1, rel_cyc[1] - last_cyc[1], 1);
    chk("basic_state_idle", 0, if_a.state_dbg, 0);

    // Alternation with both banks full; rd_enable drops mid-bank on dut1
    do_reset();
    start(1'b1, 2'b11, 1'b1);
    done = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      if (a_rel_q.size() >= 3) begin
        done = 1;
        break;
      end
    end
    chk("alt_three_banks", 0, done, 1);
    rd_enable = 1'b0;
    wait_idle("alt_idle", 300);
    chk("alt_rel0", 0, rel_at(0), 2'b01);
    chk("alt_rel1", 0, rel_at(1), 2'b10);
    chk("alt_rel2", 0, rel_at(2), 2'b01);
    chk("alt_en_cnt", 0, en_cnt[0], 48);
    chk("alt_rel_cnt_b", 1, rel_cnt[1], 2);
    chk("alt_en_cnt_b", 1, en_cnt[1], 64);

    // Stall for 3 cycles at (addr 1, slice 2)
    do_reset();
    start(1'b1, 2'b01, 1'b1);
    cycles(7);
    sa_advance = 1'b0;
    cycles(3);
    sa_advance = 1'b1;
    wait_idle("stall_idle", 200);
    chk("stall_ov_cnt", 0, ov_cnt[0], 16);
    chk("stall_en_cnt", 0, en_cnt[0], 16);
    chk("stall_elem6", 0, issue_at(6), 4'b0110);
    chk("stall_elem7", 0, issue_at(7), 4'b0111);
    chk("stall_perf", 0, if_a.perf_stall_cnt, PERF_ON ? 3 : 0);
    chk("stall_perf", 1, if_b.perf_stall_cnt, PERF_ON ? 3 : 0);
    chk("stall_perf_bank", 0, if_a.perf_bank_cnt, PERF_ON ? 1 : 0);
    chk("stall_ov_cnt_b", 1, ov_cnt[1], 32);

    // Gating by rd_enable
    do_reset();
    start(1'b0, 2'b01, 1'b1);
    cycles(10);
    chk("gate_busy", 0, if_a.busy, 0);
    chk("gate_en_cnt", 0, en_cnt[0], 0);
    rd_enable = 1'b1;
    cycles(1);
    chk("gate_busy_next", 0, if_a.busy, 1);
    chk("gate_state_read", 0, if_a.state_dbg, 1);
    wait_idle("gate_idle", 200);
    chk("gate_ov_cnt", 0, ov_cnt[0], 16);

    // Async reset while element 7 is on the enables
    do_reset();
    start(1'b1, 2'b01, 1'b1);
    cycles(9);
    chk("rst_pre_elem", 0, issue_at(6), 4'b0110);
    rst_n = 1'b0;
    #1;
    chk("rst_now_en0", 0, if_a.bank0_en, 0);
    chk("rst_now_addr", 0, if_a.rd_addr, 0);
    chk("rst_now_slice", 0, if_a.slicing_idx, 0);
    chk("rst_now_valid", 0, if_a.out_valid, 0);
    chk("rst_now_busy", 0, if_a.busy, 0);
    chk("rst_no_release", 0, rel_cnt[0], 0);
    cycles(2);
    clear_mon();
    rst_n = 1'b1;
    cycles(3);
    wait_idle("rst_restart_idle", 200);
    chk("rst_restart_first", 0, issue_at(0), 4'h0);
    chk("rst_restart_bank", 0, a_first_en, 2'b01);
    chk("rst_restart_en_cnt", 0, en_cnt[0], 16);
    chk("rst_restart_rel", 0, rel_at(0), 2'b01);

    cycles(4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
